// File: rtl/sdf_ms_collector_if.sv
// ----------------------------------------------------------------------------
// sdf_ms_collector_if
//
// Purpose:
//   Bundles the multi-lane producer side and the single-stream consumer side
//   of the SDF multi-stream collector.
//
// Signals:
//   in_wr    [FLUX]        per-lane write strobe, bit i writes lane i
//   in_data  [FLUX*WIDTH]  lane i token on bits [i*WIDTH +: WIDTH]
//   in_full  [FLUX]        bit i high while lane i holds DEPTH tokens
//   out_wr                 registered write strobe towards the consumer
//   out_data [WIDTH]       registered token, valid while out_wr=1
//   out_full               consumer cannot accept, sampled at the clock edge
//
// Modports:
//   master - the environment (producers and consumer)
//   slave  - the collector itself
// ----------------------------------------------------------------------------
interface sdf_ms_collector_if #(
    parameter int WIDTH = 8,
    parameter int FLUX  = 2
);
    logic [FLUX-1:0]       in_wr;
    logic [FLUX*WIDTH-1:0] in_data;
    logic [FLUX-1:0]       in_full;
    logic                  out_wr;
    logic [WIDTH-1:0]      out_data;
    logic                  out_full;

    modport master (
        output in_wr,
        output in_data,
        output out_full,
        input  in_full,
        input  out_wr,
        input  out_data
    );

    modport slave (
        input  in_wr,
        input  in_data,
        input  out_full,
        output in_full,
        output out_wr,
        output out_data
    );
endinterface

// File: rtl/sdf_ms_collector.sv
// ----------------------------------------------------------------------------
// sdf_ms_collector
//
// Purpose:
//   Output-side counterpart of the multi-stream FIFO in front of SDF actors.
//   FLUX independent producer lanes are buffered separately, then drained in
//   strict round-robin order (lane 0, 1, ..., FLUX-1, 0, ...) onto a single
//   write/full stream, restoring a token sequence that was split over lanes.
//   The sequencer never skips an empty lane: it waits on it.
//
// Parameters:
//   WIDTH  token width in bits
//   FLUX   number of input lanes (>= 2)
//   DEPTH  per-lane buffer depth in tokens (power of 2, >= 2)
//
// Ports:
//   i_ck       clock, all state updates on the rising edge
//   i_rst      asynchronous reset, active low
//   bus        sdf_ms_collector_if.slave (lane inputs, serial output)
//   o_tok_cnt  (optional) 16-bit wrapping count of emitted tokens
//   o_ovf      (optional) sticky per-lane flag: write attempted while full
//
// Configuration:
//   SDF_MS_COLLECT_STATS_EN  when defined, adds o_tok_cnt / o_ovf and their
//                            registers; otherwise they do not exist.
// ----------------------------------------------------------------------------
module sdf_ms_collector #(
    parameter int WIDTH = 8,
    parameter int FLUX  = 2,
    parameter int DEPTH = 16
) (
    input  logic                 i_ck,
    input  logic                 i_rst,
    sdf_ms_collector_if.slave    bus
`ifdef SDF_MS_COLLECT_STATS_EN
    ,
    output logic [15:0]          o_tok_cnt,
    output logic [FLUX-1:0]      o_ovf
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int SW = (FLUX > 1) ? $clog2(FLUX) : 1;
    localparam logic [SW-1:0] SEL_LAST = SW'(FLUX - 1);

    // Per-lane status and read ports, gathered from the lane generate blocks
    logic [FLUX-1:0]  w_empty;
    logic [FLUX-1:0]  w_full;
    logic [FLUX-1:0]  w_pop;
    logic [WIDTH-1:0] w_rd_data [FLUX];

    // Sequencer state and output registers
    logic [SW-1:0]    r_sel;
    logic [SW-1:0]    w_sel_next;
    logic             w_emit;
    logic             r_out_wr;
    logic [WIDTH-1:0] r_out_data;

    // ------------------------------------------------------------------------
    // Lane buffers: one circular RAM per lane with wrap-bit pointers, so that
    // full and empty are distinguishable without an occupancy counter.
    // ------------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < FLUX; gi++) begin : g_lane
            logic [WIDTH-1:0] r_mem [DEPTH];
            logic [AW:0]      r_wp;
            logic [AW:0]      r_rp;
            logic             w_wr_ok;

            assign w_empty[gi] = (r_wp == r_rp);
            assign w_full[gi]  = (r_wp[AW] != r_rp[AW]) &&
                                 (r_wp[AW-1:0] == r_rp[AW-1:0]);

            // A write is judged against the full flag before this edge, so a
            // pop on a full lane does not make room for a same-edge write.
            assign w_wr_ok = bus.in_wr[gi] && !w_full[gi];

            // Only the currently selected lane can be popped
            assign w_pop[gi] = w_emit && (r_sel == SW'(gi));

            assign w_rd_data[gi] = r_mem[r_rp[AW-1:0]];

            // Storage carries no reset: stale contents are unreachable once
            // the pointers are cleared.
            always_ff @(posedge i_ck) begin
                if (w_wr_ok) begin
                    r_mem[r_wp[AW-1:0]] <= bus.in_data[gi*WIDTH +: WIDTH];
                end
            end

            always_ff @(posedge i_ck or negedge i_rst) begin
                if (!i_rst) begin
                    r_wp <= '0;
                    r_rp <= '0;
                end else begin
                    if (w_wr_ok) begin
                        r_wp <= r_wp + (AW+1)'(1);
                    end
                    if (w_pop[gi]) begin
                        r_rp <= r_rp + (AW+1)'(1);
                    end
                end
            end
        end
    endgenerate

    // ------------------------------------------------------------------------
    // Round-robin sequencer, next-state logic.
    // A token is emitted only when the consumer is ready and the selected lane
    // already held data before this edge; there is no write-through bypass.
    // ------------------------------------------------------------------------
    always_comb begin
        w_emit     = 1'b0;
        w_sel_next = r_sel;
        if (!bus.out_full && !w_empty[r_sel]) begin
            w_emit = 1'b1;
            if (r_sel == SEL_LAST) begin
                w_sel_next = '0;
            end else begin
                w_sel_next = r_sel + SW'(1);
            end
        end
    end

    // Sequencer state register and registered output stage
    always_ff @(posedge i_ck or negedge i_rst) begin
        if (!i_rst) begin
            r_sel      <= '0;
            r_out_wr   <= 1'b0;
            r_out_data <= '0;
        end else begin
            r_sel    <= w_sel_next;
            r_out_wr <= w_emit;
            // out_data holds its last value during stalls
            if (w_emit) begin
                r_out_data <= w_rd_data[r_sel];
            end
        end
    end

    assign bus.in_full  = w_full;
    assign bus.out_wr   = r_out_wr;
    assign bus.out_data = r_out_data;

`ifdef SDF_MS_COLLECT_STATS_EN
    // ------------------------------------------------------------------------
    // Statistics: emitted-token counter (wraps) and sticky overflow flags.
    // ------------------------------------------------------------------------
    logic [15:0]     r_tok_cnt;
    logic [FLUX-1:0] r_ovf;

    always_ff @(posedge i_ck or negedge i_rst) begin
        if (!i_rst) begin
            r_tok_cnt <= '0;
            r_ovf     <= '0;
        end else begin
            if (w_emit) begin
                r_tok_cnt <= r_tok_cnt + 16'd1;
            end
            r_ovf <= r_ovf | (bus.in_wr & w_full);
        end
    end

    assign o_tok_cnt = r_tok_cnt;
    assign o_ovf     = r_ovf;
`endif

endmodule

// File: tb/tb_sdf_ms_collector.sv
// ----------------------------------------------------------------------------
// tb_sdf_ms_collector
//
// Bench for sdf_ms_collector with WIDTH=8, FLUX=2, DEPTH=4.
// A queue-based model tracks per-lane contents and the round-robin pointer;
// a compare process checks the DUT against it on every falling clock edge.
// Directed tests additionally pin the output order to literal sequences.
// Inputs change 2 time units after each rising edge.
// ----------------------------------------------------------------------------
module tb_sdf_ms_collector;

    localparam int WIDTH = 8;
    localparam int FLUX  = 2;
    localparam int DEPTH = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    sdf_ms_collector_if #(.WIDTH(WIDTH), .FLUX(FLUX)) bus ();

`ifdef SDF_MS_COLLECT_STATS_EN
    logic [15:0]     tok_cnt;
    logic [FLUX-1:0] ovf;
`endif

    sdf_ms_collector #(.WIDTH(WIDTH), .FLUX(FLUX), .DEPTH(DEPTH)) dut (
        .i_ck      (clk),
        .i_rst     (rst_n),
        .bus       (bus)
`ifdef SDF_MS_COLLECT_STATS_EN
        ,
        .o_tok_cnt (tok_cnt),
        .o_ovf     (ovf)
`endif
    );

    always #5 clk = ~clk;

    // ---------------- bookkeeping ----------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [WIDTH-1:0] mq [FLUX][$];
    int               m_sel      = 0;
    logic             m_out_wr   = 1'b0;
    logic [WIDTH-1:0] m_out_data = '0;
    logic [FLUX-1:0]  m_in_full  = '0;
    logic             m_prev_full = 1'b0;
    int               m_accepted = 0;
    int               m_emitted  = 0;
    logic [FLUX-1:0]  m_ovf      = '0;

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                for (int i = 0; i < FLUX; i++) mq[i].delete();
                m_sel       = 0;
                m_out_wr    = 1'b0;
                m_out_data  = '0;
                m_in_full   = '0;
                m_prev_full = 1'b0;
                m_accepted  = 0;
                m_emitted   = 0;
                m_ovf       = '0;
            end else begin
                bit emit;
                // decisions use the lane contents from before this edge
                emit = !bus.out_full && (mq[m_sel].size() != 0);
                for (int i = 0; i < FLUX; i++) begin
                    if (bus.in_wr[i]) begin
                        if (mq[i].size() < DEPTH) begin
                            mq[i].push_back(bus.in_data[i*WIDTH +: WIDTH]);
                            m_accepted++;
                        end else begin
                            m_ovf[i] = 1'b1;
                        end
                    end
                end
                if (emit) begin
                    m_out_data = mq[m_sel].pop_front();
                    m_out_wr   = 1'b1;
                    m_sel      = (m_sel + 1) % FLUX;
                    m_emitted++;
                end else begin
                    m_out_wr = 1'b0;
                end
                m_prev_full = bus.out_full;
                for (int i = 0; i < FLUX; i++) m_in_full[i] = (mq[i].size() == DEPTH);
            end
        end
    end

    // ---------------- compare process ----------------
    logic [WIDTH-1:0] got [$];
    int               dut_cnt  = 0;
    bit               check_en = 0;

    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) dut_cnt = 0;
            if (check_en) begin
                check("out_wr",   32'(bus.out_wr),   32'(m_out_wr));
                check("out_data", 32'(bus.out_data), 32'(m_out_data));
                check("in_full",  32'(bus.in_full),  32'(m_in_full));
                if (m_prev_full) check("bp_stall", 32'(bus.out_wr), 32'd0);
`ifdef SDF_MS_COLLECT_STATS_EN
                check("tok_cnt", 32'(tok_cnt), 32'(m_emitted[15:0]));
                check("ovf",     32'(ovf),     32'(m_ovf));
`endif
                if (bus.out_wr) begin
                    got.push_back(bus.out_data);
                    dut_cnt++;
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    logic [WIDTH-1:0] exp_q [$];

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cyc();
    endtask

    // one edge with the given strobes and lane data, strobes dropped after
    task automatic drive(input logic [FLUX-1:0] wr, input logic [WIDTH-1:0] d0, input logic [WIDTH-1:0] d1);
        bus.in_wr   = wr;
        bus.in_data = {d1, d0};
        cyc();
        bus.in_wr   = '0;
    endtask

    task automatic check_got(input string name);
        check({name, "_len"}, 32'(got.size()), 32'(exp_q.size()));
        for (int k = 0; k < exp_q.size() && k < got.size(); k++)
            check(name, 32'(got[k]), 32'(exp_q[k]));
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle(2);
        rst_n = 1'b1;
        cyc();
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- directed tests ----------------
    initial begin
        int start;
        int k;
        bit seen;

        bus.in_wr    = '0;
        bus.in_data  = '0;
        bus.out_full = 1'b0;
        rst_n        = 1'b0;
        cyc();
        check_en = 1;
        idle(2);
        rst_n = 1'b1;

        // 1. reset / idle
        idle(20);
        check("idle_out_wr",   32'(bus.out_wr),   32'd0);
        check("idle_out_data", 32'(bus.out_data), 32'd0);
        check("idle_in_full",  32'(bus.in_full),  32'd0);

        // 2. order restore: lane1 written first must wait for lane0
        got.delete();
        drive(2'b10, 8'h00, 8'hB1);
        drive(2'b01, 8'hA0, 8'h00);
        drive(2'b01, 8'hA2, 8'h00);
        drive(2'b10, 8'h00, 8'hB3);
        idle(6);
        exp_q = {8'hA0, 8'hB1, 8'hA2, 8'hB3};
        check_got("order");

        // 3. full / drop with DEPTH=4 under backpressure
        bus.out_full = 1'b1;
        drive(2'b01, 8'h10, 8'h00);
        drive(2'b01, 8'h11, 8'h00);
        drive(2'b01, 8'h12, 8'h00);
        check("not_full_3", 32'(bus.in_full), 32'd0);
        drive(2'b01, 8'h13, 8'h00);
        check("full_after_4", 32'(bus.in_full), 32'b01);
        drive(2'b01, 8'h14, 8'h00);
        check("full_after_drop", 32'(bus.in_full), 32'b01);
        for (int i = 0; i < 4; i++) drive(2'b10, 8'h00, 8'(8'h20 + i));
        check("both_full", 32'(bus.in_full), 32'b11);
        got.delete();
        bus.out_full = 1'b0;
        idle(12);
        exp_q = {8'h10, 8'h20, 8'h11, 8'h21, 8'h12, 8'h22, 8'h13, 8'h23};
        check_got("drain");
        check("drain_in_full", 32'(bus.in_full), 32'd0);

        // 4. random streaming with backpressure, 1000 accepted tokens
        start = m_accepted;
        k = 0;
        while ((m_accepted - start) < 1000 && k < 20000) begin
            bus.in_wr    = FLUX'($urandom_range(0, 3));
            bus.in_data  = 16'($urandom);
            bus.out_full = (k < 1000) ? k[0] : ($urandom_range(0, 3) == 0);
            cyc();
            k++;
        end
        check("rand_accepted", 32'((m_accepted - start) >= 1000), 32'd1);
        bus.in_wr    = '0;
        bus.out_full = 1'b0;
        // strict order stalls on an empty lane, so top up the selected lane
        for (int n = 0; n < 400; n++) begin
            if (mq[0].size() == 0 && mq[1].size() == 0) break;
            if (mq[m_sel].size() == 0) begin
                bus.in_wr[m_sel] = 1'b1;
                bus.in_data      = 16'($urandom);
            end
            cyc();
            bus.in_wr = '0;
        end
        idle(3);
        check("drain_empty", 32'(mq[0].size() + mq[1].size()), 32'd0);
        check("token_count", 32'(dut_cnt), 32'(m_accepted));

        // 5. asynchronous reset while a token is being presented
        bus.out_full = 1'b1;
        for (int i = 0; i < 3; i++) drive(2'b11, 8'(8'h70 + i), 8'(8'h80 + i));
        bus.out_full = 1'b0;
        seen = 0;
        for (int n = 0; n < 20; n++) begin
            cyc();
            if (bus.out_wr) begin
                seen = 1;
                break;
            end
        end
        check("stream_seen", 32'(seen), 32'd1);
        rst_n = 1'b0;
        #1;
        check("async_out_wr",   32'(bus.out_wr),   32'd0);
        check("async_out_data", 32'(bus.out_data), 32'd0);
        check("async_in_full",  32'(bus.in_full),  32'd0);
        idle(2);
        rst_n = 1'b1;
        got.delete();
        idle(10);
        check("no_stale_tokens", 32'(got.size()), 32'd0);
        drive(2'b10, 8'h00, 8'h6B);
        drive(2'b01, 8'h5A, 8'h00);
        idle(5);
        exp_q = {8'h5A, 8'h6B};
        check_got("sel_restart");

`ifdef SDF_MS_COLLECT_STATS_EN
        // 6. statistics: three emits, then overflow lane 1
        do_reset();
        drive(2'b11, 8'h01, 8'h02);
        drive(2'b01, 8'h03, 8'h00);
        idle(4);
        bus.out_full = 1'b1;
        for (int i = 0; i < 5; i++) drive(2'b10, 8'h00, 8'(8'h40 + i));
        check("stats_tok_cnt", 32'(tok_cnt), 32'd3);
        check("stats_ovf",     32'(ovf),     32'b10);
        idle(5);
        check("stats_tok_hold", 32'(tok_cnt), 32'd3);
        check("stats_ovf_hold", 32'(ovf),     32'b10);
        bus.out_full = 1'b0;
        do_reset();
        check("stats_tok_rst", 32'(tok_cnt), 32'd0);
        check("stats_ovf_rst", 32'(ovf),     32'd0);
`else
        do_reset();
`endif
        idle(3);
        check("final_out_wr", 32'(bus.out_wr), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sdf_ms_collector.md
Name: sdf_ms_collector

Overview:
- Output-side counterpart of the multi-stream FIFO used in front of SDF actors.
- Accepts FLUX independent producer streams, each with a write/full handshake, and buffers each lane separately.
- Re-serialises the lanes in strict round-robin order (lane 0, 1, ..., FLUX-1, 0, ...) onto one write/full output stream, so a token sequence split across lanes is restored.
- Sits between a multi-flux actor/FIFO_MS-style source and a single-stream consumer port.

Parameters:
- WIDTH, 8, token width in bits.
- FLUX, 2, number of input lanes (>=2).
- DEPTH, 16, per-lane buffer depth in tokens; power of 2, >=2.

Ports:
- ck  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous reset, active-low: rst=0 resets immediately, independent of ck.
- in_wr  input  FLUX  per-lane write strobe; bit i writes lane i.
- in_data  input  FLUX*WIDTH  lane i token on bits [i*WIDTH +: WIDTH].
- in_full  output  FLUX  bit i high when lane i holds DEPTH tokens.
- out_wr  output  1  registered write strobe to consumer; one token per high cycle.
- out_data  output  WIDTH  registered token; valid when out_wr=1.
- out_full  input  1  consumer cannot accept; sampled at the edge.

Behaviour:
- Reset (rst=0): all lane read/write pointers to 0, lane select `sel` to 0, out_wr=0, out_data=0, in_full=0; buffered tokens discarded. Applies mid-operation; an in-flight out_wr drops in the same cycle.
- Lane buffer: circular RAM of DEPTH entries, pointers log2(DEPTH)+1 bits with wrap bit.
  - empty_i = (wp==rp); full_i = (wp[MSB]!=rp[MSB]) && equal low bits.
  - in_full[i] = full_i (combinational from registers).
- Write: at the edge, if in_wr[i]=1 and full_i=0, store in_data lane i at wp_i and increment wp_i. If full_i=1 the write is dropped, with no state change.
- Sequencer, state = sel in 0..FLUX-1. At each edge:
  - EMIT: out_full=0 and lane sel non-empty → out_data<=mem_sel[rp_sel], out_wr<=1, rp_sel++, sel<=(sel==FLUX-1)?0:sel+1.
  - WAIT: otherwise out_wr<=0, out_data holds its value, sel unchanged. Lane sel empty is never skipped; order is strict.
- Latency: token written at edge k into an empty lane that equals sel (out_full=0) → out_wr=1 in the cycle after edge k+1. There is no same-cycle bypass.
- Same-edge write and pop on one lane: both take effect. A pop on a full lane clears in_full after that edge only; a write presented at that edge is still dropped.
- out_full=1 at an edge blocks the pop and forces out_wr=0 for the next cycle. A token already registered is considered accepted.
- Per-lane occupancy never exceeds DEPTH; pointers wrap naturally.

Optional Feature:
- Macro SDF_MS_COLLECT_STATS_EN.
- When defined, two extra outputs are added:
  - tok_cnt [15:0]: increments on each EMIT and wraps at 16'hFFFF→0.
  - ovf [FLUX-1:0]: bit i sticky-set when in_wr[i]=1 while full_i=1.
  - Both reset to 0 on rst=0 and are cleared only by reset.
- When undefined, these ports and their registers are absent; all other behaviour is identical.

Test Plan:
- Reset/idle: rst=0 then 1, no writes → out_wr=0, out_data=0, in_full=0 for 20 cycles.
- Order restore (FLUX=2): write lane1=0xB1 first, then lane0=0xA0, lane0=0xA2, lane1=0xB3 → out_data sequence A0,B1,A2,B3. No output while lane0 is empty.
- Full/drop (DEPTH=4, out_full=1): 5 writes to lane0 (0x10..0x14) → in_full[0]=1 after 4th edge, 0x14 dropped. Release out_full with lane1 filled 0x20..0x23 → 10,20,11,21,12,22,13,23, then stall.
- Backpressure: during streaming, toggle out_full 1-cycle on/off → out_wr never high in the cycle after out_full=1 is sampled. No token lost or duplicated (scoreboard over 1000 random tokens).
- Async reset mid-stream: assert rst=0 between edges while out_wr=1 → out_wr=0 immediately. After release, previously buffered tokens never appear and sel restarts at lane 0.
- With SDF_MS_COLLECT_STATS_EN: emit 3 tokens, then overflow lane1 → tok_cnt=3, ovf=2'b10, held until reset.
